// File: rtl/sysarr_pkg.sv
// Shared types and helpers for the systolic array tile scheduler.
package sysarr_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ISSUE,
      DRAIN,
      DONE
   } sched_state_t;

   // Address of a tile word; callers truncate to their own bus width.
   function automatic logic [31:0] tile_addr(
      input logic [31:0] base,
      input logic [31:0] step,
      input logic [31:0] row,
      input logic [31:0] mesh,
      input logic [31:0] words
   );
      return base + (step * mesh + row) * words;
   endfunction

endpackage

// File: rtl/tile_delay_line.sv
// Per-row valid/address shift register that delays C writes by DEPTH cycles.
module tile_delay_line #(
   parameter int BITWIDTH  = 8,
   parameter int MESHUNITS = 2,
   parameter int DEPTH     = 3
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic [MESHUNITS-1:0]                in_valid,
   input  logic [MESHUNITS-1:0][BITWIDTH-1:0]  in_addr,
   output logic [MESHUNITS-1:0]                out_valid,
   output logic [MESHUNITS-1:0][BITWIDTH-1:0]  out_addr
);

   logic [MESHUNITS-1:0]               vld [DEPTH];
   logic [MESHUNITS-1:0][BITWIDTH-1:0] adr [DEPTH];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int d = 0; d < DEPTH; d++) begin
            vld[d] <= '0;
            adr[d] <= '0;
         end
      end else begin
         vld[0] <= in_valid;
         adr[0] <= in_addr;
         for (int d = 1; d < DEPTH; d++) begin
            vld[d] <= vld[d-1];
            adr[d] <= adr[d-1];
         end
      end
   end

   assign out_valid = vld[DEPTH-1];
   assign out_addr  = adr[DEPTH-1];

endmodule

// File: rtl/tile_scheduler.sv
// Skewed tile read/write address scheduler for a MESHUNITS-row systolic array,
// sharing memory with a loader that has priority while idle.
import sysarr_pkg::*;

module tile_scheduler #(
   parameter int BITWIDTH      = 8,
   parameter int MESHUNITS     = 2,
   parameter int TILEUNITS     = 4,
   parameter int ARRAY_LATENCY = 3
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               cmd_valid,
   output logic                               cmd_ready,
   input  logic [BITWIDTH-1:0]                cmd_a_base,
   input  logic [BITWIDTH-1:0]                cmd_b_base,
   input  logic [BITWIDTH-1:0]                cmd_d_base,
   input  logic [BITWIDTH-1:0]                cmd_c_base,
   input  logic [BITWIDTH-1:0]                cmd_rows,
   input  logic                               loader_req,
   output logic                               loader_grant,
   output logic [MESHUNITS-1:0][BITWIDTH-1:0] A_tile_read_addrs,
   output logic [MESHUNITS-1:0][BITWIDTH-1:0] B_tile_read_addrs,
   output logic [MESHUNITS-1:0][BITWIDTH-1:0] D_tile_read_addrs,
   output logic [MESHUNITS-1:0]               A_read_valid,
   output logic [MESHUNITS-1:0]               B_read_valid,
   output logic [MESHUNITS-1:0]               D_read_valid,
   output logic [MESHUNITS-1:0][BITWIDTH-1:0] C_tile_write_addrs,
   output logic [MESHUNITS-1:0]               C_write_valid,
   output logic                               busy,
   output logic                               done
);

   localparam logic [BITWIDTH-1:0] ALIGN = ~BITWIDTH'(TILEUNITS - 1);

   sched_state_t state;
   sched_state_t next_state;

   logic [BITWIDTH-1:0] a_base;
   logic [BITWIDTH-1:0] b_base;
   logic [BITWIDTH-1:0] d_base;
   logic [BITWIDTH-1:0] c_base;
   logic [BITWIDTH-1:0] rows;
   logic [31:0]         cnt;
   logic [31:0]         last_t;
   logic                accept;

   logic [MESHUNITS-1:0]               rd_valid;
   logic [MESHUNITS-1:0][BITWIDTH-1:0] c_addr;

   assign accept = cmd_valid && cmd_ready;
   assign last_t = 32'(rows) + 32'(MESHUNITS) - 32'd2;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (loader_req) begin
               next_state = LOAD;
            end else if (accept) begin
               next_state = (cmd_rows == '0) ? DONE : ISSUE;
            end
         end
         LOAD: begin
            if (!loader_req) begin
               next_state = IDLE;
            end
         end
         ISSUE: begin
            if (cnt == last_t) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (cnt == 32'(ARRAY_LATENCY - 1)) begin
               next_state = DONE;
            end
         end
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready    = (state == IDLE) && !loader_req && !reset;
      loader_grant = (state == LOAD);
      busy         = (state != IDLE);
      done         = (state == DONE);
   end

   // One counter serves both ISSUE (skew cycle t) and DRAIN; it restarts on every state change.
   always_ff @(posedge clock) begin
      if (reset || (state != next_state)) begin
         cnt <= '0;
      end else if (state == ISSUE || state == DRAIN) begin
         cnt <= cnt + 32'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         a_base <= '0;
         b_base <= '0;
         d_base <= '0;
         c_base <= '0;
         rows   <= '0;
      end else if (accept) begin
         a_base <= cmd_a_base & ALIGN;
         b_base <= cmd_b_base & ALIGN;
         d_base <= cmd_d_base & ALIGN;
         c_base <= cmd_c_base & ALIGN;
         rows   <= cmd_rows;
      end
   end

   always_comb begin
      rd_valid          = '0;
      A_tile_read_addrs = '0;
      B_tile_read_addrs = '0;
      D_tile_read_addrs = '0;
      c_addr            = '0;
      for (int i = 0; i < MESHUNITS; i++) begin
         if (state == ISSUE && cnt >= 32'(i) && (cnt - 32'(i)) < 32'(rows)) begin
            rd_valid[i] = 1'b1;
            A_tile_read_addrs[i] = BITWIDTH'(tile_addr(32'(a_base), cnt - 32'(i),
               32'(i), 32'(MESHUNITS), 32'(TILEUNITS)));
            B_tile_read_addrs[i] = BITWIDTH'(tile_addr(32'(b_base), cnt - 32'(i),
               32'(i), 32'(MESHUNITS), 32'(TILEUNITS)));
            D_tile_read_addrs[i] = BITWIDTH'(tile_addr(32'(d_base), cnt - 32'(i),
               32'(i), 32'(MESHUNITS), 32'(TILEUNITS)));
            c_addr[i] = BITWIDTH'(tile_addr(32'(c_base), cnt - 32'(i),
               32'(i), 32'(MESHUNITS), 32'(TILEUNITS)));
         end
      end
   end

   assign A_read_valid = rd_valid;
   assign B_read_valid = rd_valid;
   assign D_read_valid = rd_valid;

   tile_delay_line #(
      .BITWIDTH  (BITWIDTH),
      .MESHUNITS (MESHUNITS),
      .DEPTH     (ARRAY_LATENCY)
   ) u_c_delay (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (rd_valid),
      .in_addr   (c_addr),
      .out_valid (C_write_valid),
      .out_addr  (C_tile_write_addrs)
   );

endmodule

// File: tb/tb_tile_scheduler.sv
// Randomized bench for tile_scheduler against a cycle-timeline model of reads, writes and handshakes.
module tb_tile_scheduler;

   localparam int BW = 8;
   localparam int M  = 2;
   localparam int TU = 4;
   localparam int L  = 3;
   localparam int N  = 4000;

   logic clock;
   logic reset;
   logic cmd_valid;
   logic cmd_ready;
   logic [BW-1:0] cmd_a_base, cmd_b_base, cmd_d_base, cmd_c_base, cmd_rows;
   logic loader_req;
   logic loader_grant;
   logic [M-1:0][BW-1:0] A_tile_read_addrs, B_tile_read_addrs, D_tile_read_addrs;
   logic [M-1:0] A_read_valid, B_read_valid, D_read_valid;
   logic [M-1:0][BW-1:0] C_tile_write_addrs;
   logic [M-1:0] C_write_valid;
   logic busy;
   logic done;

   tile_scheduler #(
      .BITWIDTH(BW), .MESHUNITS(M), .TILEUNITS(TU), .ARRAY_LATENCY(L)
   ) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a_base(cmd_a_base), .cmd_b_base(cmd_b_base),
      .cmd_d_base(cmd_d_base), .cmd_c_base(cmd_c_base),
      .cmd_rows(cmd_rows),
      .loader_req(loader_req), .loader_grant(loader_grant),
      .A_tile_read_addrs(A_tile_read_addrs),
      .B_tile_read_addrs(B_tile_read_addrs),
      .D_tile_read_addrs(D_tile_read_addrs),
      .A_read_valid(A_read_valid), .B_read_valid(B_read_valid),
      .D_read_valid(D_read_valid),
      .C_tile_write_addrs(C_tile_write_addrs), .C_write_valid(C_write_valid),
      .busy(busy), .done(done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Model: expected outputs per absolute cycle plus a coarse idle/load/run mode.
   logic [M-1:0]         ev_rv [N];
   logic [M-1:0][BW-1:0] ev_a  [N];
   logic [M-1:0][BW-1:0] ev_b  [N];
   logic [M-1:0][BW-1:0] ev_d  [N];
   logic [M-1:0]         ev_cv [N];
   logic [M-1:0][BW-1:0] ev_c  [N];

   int mode;
   int done_at;
   int cyc_n;
   int passed;
   int total;

   function automatic logic [BW-1:0] taddr(int base, int s, int i);
      int v;
      v = (base & ~(TU - 1)) + (s * M + i) * TU;
      return v[BW-1:0];
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s cycle %0d: got %h want %h", nm, cyc_n, act, exp);
      end
   endtask

   task automatic model_check();
      if (reset) return;
      chk("cmd_ready", 32'(cmd_ready), 32'(mode == 0 && !loader_req));
      chk("loader_grant", 32'(loader_grant), 32'(mode == 1));
      chk("busy", 32'(busy), 32'(mode != 0));
      chk("done", 32'(done), 32'(mode == 2 && cyc_n == done_at));
      chk("a_valid", 32'(A_read_valid), 32'(ev_rv[cyc_n]));
      chk("b_valid", 32'(B_read_valid), 32'(ev_rv[cyc_n]));
      chk("d_valid", 32'(D_read_valid), 32'(ev_rv[cyc_n]));
      chk("a_addr", 32'(A_tile_read_addrs), 32'(ev_a[cyc_n]));
      chk("b_addr", 32'(B_tile_read_addrs), 32'(ev_b[cyc_n]));
      chk("d_addr", 32'(D_tile_read_addrs), 32'(ev_d[cyc_n]));
      chk("c_valid", 32'(C_write_valid), 32'(ev_cv[cyc_n]));
      chk("c_addr", 32'(C_tile_write_addrs), 32'(ev_c[cyc_n]));
   endtask

   task automatic schedule();
      int r;
      int rc;
      r = int'(cmd_rows);
      for (int s = 0; s < r; s++) begin
         for (int i = 0; i < M; i++) begin
            rc = cyc_n + 1 + s + i;
            ev_rv[rc][i]   = 1'b1;
            ev_a[rc][i]    = taddr(int'(cmd_a_base), s, i);
            ev_b[rc][i]    = taddr(int'(cmd_b_base), s, i);
            ev_d[rc][i]    = taddr(int'(cmd_d_base), s, i);
            ev_cv[rc+L][i] = 1'b1;
            ev_c[rc+L][i]  = taddr(int'(cmd_c_base), s, i);
         end
      end
      done_at = cyc_n + 1 + ((r == 0) ? 0 : r + M - 1 + L);
      mode = 2;
   endtask

   task automatic model_update();
      if (reset) begin
         mode = 0;
         for (int k = cyc_n + 1; k < N; k++) begin
            ev_rv[k] = '0; ev_a[k] = '0; ev_b[k] = '0; ev_d[k] = '0;
            ev_cv[k] = '0; ev_c[k] = '0;
         end
      end else begin
         case (mode)
            0: begin
               if (loader_req) mode = 1;
               else if (cmd_valid) schedule();
            end
            1: if (!loader_req) mode = 0;
            default: if (cyc_n == done_at) mode = 0;
         endcase
      end
   endtask

   task automatic settle();
      @(negedge clock);
   endtask

   task automatic finish_cyc();
      model_check();
      model_update();
      @(posedge clock);
      #1;
      cyc_n++;
   endtask

   task automatic cyc();
      settle();
      finish_cyc();
   endtask

   task automatic send(logic [BW-1:0] a, logic [BW-1:0] c, logic [BW-1:0] r);
      cmd_a_base = a;
      cmd_b_base = a + 8'h20;
      cmd_d_base = a + 8'h40;
      cmd_c_base = c;
      cmd_rows   = r;
      cmd_valid  = 1'b1;
      cyc();
      cmd_valid  = 1'b0;
   endtask

   initial begin
      passed = 0; total = 0; cyc_n = 0; mode = 0; done_at = 0;
      for (int k = 0; k < N; k++) begin
         ev_rv[k] = '0; ev_a[k] = '0; ev_b[k] = '0; ev_d[k] = '0;
         ev_cv[k] = '0; ev_c[k] = '0;
      end
      reset = 1'b1; cmd_valid = 1'b0; loader_req = 1'b0;
      cmd_a_base = '0; cmd_b_base = '0; cmd_d_base = '0;
      cmd_c_base = '0; cmd_rows = '0;
      cyc();
      cyc();
      reset = 1'b0;
      settle();
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cvalid", 32'(C_write_valid), 32'd0);
      finish_cyc();

      // Basic skew and C latency.
      send(8'h10, 8'h40, 8'd2);
      for (int t = 0; t < 8; t++) begin
         settle();
         case (t)
            0: begin
               chk("t0_av", 32'(A_read_valid), 32'h1);
               chk("t0_aa", 32'(A_tile_read_addrs), 32'h0010);
            end
            1: begin
               chk("t1_av", 32'(A_read_valid), 32'h3);
               chk("t1_aa", 32'(A_tile_read_addrs), 32'h1418);
            end
            2: begin
               chk("t2_av", 32'(A_read_valid), 32'h2);
               chk("t2_aa", 32'(A_tile_read_addrs), 32'h1C00);
            end
            3: chk("t3_ca", 32'({C_write_valid, C_tile_write_addrs}), 32'h10040);
            4: chk("t4_ca", 32'({C_write_valid, C_tile_write_addrs}), 32'h34448);
            5: begin
               chk("t5_ca", 32'({C_write_valid, C_tile_write_addrs}), 32'h24C00);
               chk("t5_done", 32'(done), 32'd0);
            end
            6: chk("t6_done", 32'(done), 32'd1);
            default: chk("t7_ready", 32'(cmd_ready), 32'd1);
         endcase
         finish_cyc();
      end

      // Unaligned base and address wrap.
      send(8'hF3, 8'hFC, 8'd2);
      for (int t = 0; t < 8; t++) begin
         settle();
         if (t == 1) chk("wr_t1_aa", 32'(A_tile_read_addrs), 32'hF4F8);
         if (t == 2) chk("wr_t2_aa", 32'(A_tile_read_addrs), 32'hFC00);
         if (t == 3) chk("wr_t3_ca", 32'(C_tile_write_addrs), 32'h00FC);
         if (t == 4) chk("wr_t4_ca", 32'(C_tile_write_addrs), 32'h0004);
         finish_cyc();
      end

      // Zero-row command completes immediately.
      send(8'h00, 8'h00, 8'd0);
      settle();
      chk("z_done", 32'(done), 32'd1);
      chk("z_valid", 32'(A_read_valid), 32'd0);
      finish_cyc();
      cyc();

      // Loader wins over a simultaneous command.
      cmd_rows = 8'd1;
      loader_req = 1'b1; cmd_valid = 1'b1;
      settle();
      chk("ld_ready", 32'(cmd_ready), 32'd0);
      finish_cyc();
      settle();
      chk("ld_grant", 32'(loader_grant), 32'd1);
      finish_cyc();
      loader_req = 1'b0;
      cyc();
      settle();
      chk("ld_accept", 32'(cmd_ready), 32'd1);
      finish_cyc();
      cmd_valid = 1'b0;
      settle();
      chk("ld_busy", 32'(busy), 32'd1);
      finish_cyc();
      for (int t = 0; t < 8; t++) cyc();

      // Loader request during a run waits for the return to idle.
      send(8'h10, 8'h40, 8'd2);
      loader_req = 1'b1;
      for (int t = 0; t < 9; t++) begin
         settle();
         if (t <= 6) chk("wait_grant0", 32'(loader_grant), 32'd0);
         if (t == 8) chk("wait_grant1", 32'(loader_grant), 32'd1);
         finish_cyc();
      end
      loader_req = 1'b0;
      cyc();
      cyc();

      // Reset mid-run drops pending C writes.
      send(8'h10, 8'h40, 8'd2);
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      for (int t = 0; t < 6; t++) begin
         settle();
         chk("rst_no_c", 32'(C_write_valid), 32'd0);
         finish_cyc();
      end

      // Randomized traffic.
      for (int n = 0; n < 1500; n++) begin
         reset      = ($urandom % 300) == 0;
         loader_req = ($urandom % 8) == 0;
         cmd_valid  = ($urandom % 3) == 0;
         cmd_a_base = BW'($urandom);
         cmd_b_base = BW'($urandom);
         cmd_d_base = BW'($urandom);
         cmd_c_base = BW'($urandom);
         cmd_rows   = (($urandom % 8) == 0) ? BW'($urandom_range(0, 30))
                                            : BW'($urandom_range(0, 5));
         cyc();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
